// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
// The request holds with a stable address until the cycle ready is seen.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: drives imem with pc and registers the returned word into IF/ID.
// Latency 1 cycle at zero wait states; stall parks a captured word in HOLD, flush redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   next_pc,
    input  logic          stall,
    input  logic          flush,
    fetch_stage_if.master imem,
    output logic [31:0]   pc,
    output logic [31:0]   if_id_inst,
    output logic [31:0]   if_id_pc,
    output logic          if_id_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] req_addr;
    logic [31:0] hold_inst;

    logic        pc_ld;
    logic        ifid_ld;
    logic        ifid_from_hold;
    logic        vld_clr;
    logic        hold_ld;
    logic        req_ld;
    logic        req;
    logic [31:0] addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_ld          = 1'b0;
        ifid_ld        = 1'b0;
        ifid_from_hold = 1'b0;
        vld_clr        = 1'b0;
        hold_ld        = 1'b0;
        req_ld         = 1'b0;
        req            = 1'b0;
        addr           = pc;
        case (state)
            FETCH: begin
                req = 1'b1;
                if (flush) begin
                    pc_ld   = 1'b1;
                    vld_clr = 1'b1;
                    // Request still outstanding: its response must be swallowed later.
                    if (!imem.imem_ready) begin
                        req_ld    = 1'b1;
                        state_nxt = DROP;
                    end
                end else if (imem.imem_ready) begin
                    if (stall) begin
                        hold_ld   = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        ifid_ld = 1'b1;
                        pc_ld   = 1'b1;
                    end
                end else if (!stall) begin
                    vld_clr = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    pc_ld     = 1'b1;
                    vld_clr   = 1'b1;
                    state_nxt = FETCH;
                end else if (!stall) begin
                    ifid_ld        = 1'b1;
                    ifid_from_hold = 1'b1;
                    pc_ld          = 1'b1;
                    state_nxt      = FETCH;
                end
            end
            DROP: begin
                req  = 1'b1;
                addr = req_addr;
                if (flush) begin
                    pc_ld = 1'b1;
                end
                if (imem.imem_ready) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    assign imem.imem_req  = req & rst_n;
    assign imem.imem_addr = addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            req_addr    <= 32'd0;
            hold_inst   <= 32'd0;
            if_id_inst  <= 32'd0;
            if_id_pc    <= 32'd0;
            if_id_valid <= 1'b0;
        end else begin
            if (pc_ld) begin
                pc <= next_pc;
            end
            if (req_ld) begin
                req_addr <= pc;
            end
            if (hold_ld) begin
                hold_inst <= imem.imem_rdata;
            end
            if (ifid_ld) begin
                if_id_inst  <= ifid_from_hold ? hold_inst : imem.imem_rdata;
                if_id_pc    <= pc;
                if_id_valid <= 1'b1;
            end else if (vld_clr) begin
                if_id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Cycle-vector bench for fetch_stage with an address-keyed memory and a delivery scoreboard.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        stall;
    logic        flush;
    logic        rdy;
    logic [31:0] pc;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic        if_id_valid;

    int tests = 0;
    int fails = 0;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_pc     (next_pc),
        .stall       (stall),
        .flush       (flush),
        .imem        (bus.master),
        .pc          (pc),
        .if_id_inst  (if_id_inst),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h0};
    endfunction

    assign bus.imem_ready = rdy;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    typedef struct {
        logic        stall;
        logic        flush;
        logic        rdy;
        logic [31:0] np;
        logic        dlv;
        logic [31:0] e_pc;
        logic        e_vld;
        logic [31:0] e_ifpc;
        logic        e_req;
        logic [31:0] e_addr;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic add(input logic s, input logic f, input logic r, input logic [31:0] np,
                       input logic d, input logic [31:0] epc, input logic ev,
                       input logic [31:0] eifpc, input logic erq, input logic [31:0] ea);
        vec_t v;
        v = '{s, f, r, np, d, epc, ev, eifpc, erq, ea};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] cur_pc;
        logic [31:0] last_inst;
        exp_t        e;

        // Reset overrides flush/stall; memory ready is ignored while in reset.
        rst_n = 1'b0; flush = 1'b1; stall = 1'b1; rdy = 1'b1; next_pc = 32'h99;
        step();
        step();
        chk("rst_pc", pc, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_ifpc", if_id_pc, 32'd0);
        chk("rst_inst", if_id_inst, 32'd0);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        rst_n = 1'b1; flush = 1'b0; stall = 1'b0;
        #1;
        chk("first_req", {31'd0, bus.imem_req}, 32'd1);
        chk("first_addr", bus.imem_addr, 32'd0);

        //  stall flush rdy next_pc       dlv e_pc          vld e_ifpc        req e_addr
        add(0, 0, 1, 32'h1,        1, 32'h1,        1, 32'h0,        1, 32'h1);
        add(0, 0, 1, 32'h2,        1, 32'h2,        1, 32'h1,        1, 32'h2);
        add(0, 0, 1, 32'h3,        1, 32'h3,        1, 32'h2,        1, 32'h3);
        add(0, 0, 0, 32'h4,        0, 32'h3,        0, 32'h2,        1, 32'h3);
        add(0, 0, 1, 32'h4,        1, 32'h4,        1, 32'h3,        1, 32'h4);
        add(0, 0, 1, 32'h5,        1, 32'h5,        1, 32'h4,        1, 32'h5);
        add(1, 0, 0, 32'h6,        0, 32'h5,        1, 32'h4,        1, 32'h5);
        add(1, 0, 1, 32'h6,        0, 32'h5,        1, 32'h4,        0, 32'h0);
        add(1, 0, 1, 32'h6,        0, 32'h5,        1, 32'h4,        0, 32'h0);
        add(1, 0, 0, 32'h6,        0, 32'h5,        1, 32'h4,        0, 32'h0);
        add(0, 0, 0, 32'h6,        1, 32'h6,        1, 32'h5,        1, 32'h6);
        add(0, 0, 1, 32'h8,        1, 32'h8,        1, 32'h6,        1, 32'h8);
        add(0, 1, 0, 32'h40,       0, 32'h40,       0, 32'h6,        1, 32'h8);
        add(0, 0, 0, 32'h41,       0, 32'h40,       0, 32'h6,        1, 32'h8);
        add(0, 0, 1, 32'h41,       0, 32'h40,       0, 32'h6,        1, 32'h40);
        add(0, 0, 1, 32'h41,       1, 32'h41,       1, 32'h40,       1, 32'h41);
        add(0, 1, 1, 32'h100,      0, 32'h100,      0, 32'h40,       1, 32'h100);
        add(0, 0, 1, 32'h101,      1, 32'h101,      1, 32'h100,      1, 32'h101);
        add(1, 0, 1, 32'h200,      0, 32'h101,      1, 32'h100,      0, 32'h0);
        add(1, 1, 0, 32'h20,       0, 32'h20,       0, 32'h100,      1, 32'h20);
        add(0, 0, 1, 32'h21,       1, 32'h21,       1, 32'h20,       1, 32'h21);
        add(0, 1, 0, 32'h30,       0, 32'h30,       0, 32'h20,       1, 32'h21);
        add(0, 1, 0, 32'h50,       0, 32'h50,       0, 32'h20,       1, 32'h21);
        add(0, 1, 1, 32'h60,       0, 32'h60,       0, 32'h20,       1, 32'h60);
        add(0, 0, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 1, 32'h60,       1, 32'hFFFFFFFF);
        add(0, 0, 1, 32'h0,        1, 32'h0,        1, 32'hFFFFFFFF, 1, 32'h0);
        add(0, 1, 0, 32'h77,       0, 32'h77,       0, 32'hFFFFFFFF, 1, 32'h0);

        cur_pc    = 32'd0;
        last_inst = 32'd0;
        foreach (vecs[i]) begin
            stall   = vecs[i].stall;
            flush   = vecs[i].flush;
            rdy     = vecs[i].rdy;
            next_pc = vecs[i].np;
            if (vecs[i].dlv) begin
                e.inst = mem_word(cur_pc);
                e.pc   = cur_pc;
                sb.push_back(e);
            end
            step();
            chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d_valid", i), {31'd0, if_id_valid}, {31'd0, vecs[i].e_vld});
            chk($sformatf("v%0d_ifpc", i), if_id_pc, vecs[i].e_ifpc);
            chk($sformatf("v%0d_req", i), {31'd0, bus.imem_req}, {31'd0, vecs[i].e_req});
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].e_addr);
            end
            if (vecs[i].dlv) begin
                if (sb.size() == 0) begin
                    chk($sformatf("v%0d_sb_empty", i), 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d_sb_inst", i), if_id_inst, e.inst);
                    chk($sformatf("v%0d_sb_pc", i), if_id_pc, e.pc);
                    last_inst = e.inst;
                end
            end else begin
                chk($sformatf("v%0d_inst_held", i), if_id_inst, last_inst);
            end
            cur_pc = vecs[i].e_pc;
        end
        chk("sb_drained", sb.size(), 32'd0);

        // Reset while in DROP with flush asserted abandons the stale request.
        rst_n = 1'b0; flush = 1'b1; stall = 1'b0; rdy = 1'b0; next_pc = 32'h88;
        step();
        chk("drop_rst_pc", pc, 32'd0);
        chk("drop_rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("drop_rst_ifpc", if_id_pc, 32'd0);
        chk("drop_rst_inst", if_id_inst, 32'd0);
        chk("drop_rst_req", {31'd0, bus.imem_req}, 32'd0);
        rst_n = 1'b1; flush = 1'b0; rdy = 1'b1; next_pc = 32'h1;
        #1;
        chk("drop_rel_req", {31'd0, bus.imem_req}, 32'd1);
        chk("drop_rel_addr", bus.imem_addr, 32'd0);
        step();
        chk("drop_rel_inst", if_id_inst, mem_word(32'd0));
        chk("drop_rel_ifpc", if_id_pc, 32'd0);
        chk("drop_rel_valid", {31'd0, if_id_valid}, 32'd1);
        chk("drop_rel_pc", pc, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'd0, word address loaded into pc on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 next_pc  input  32  next fetch word address from the branch-target stage (sequential, branch or jump target).
REQ-005 stall  input  1  downstream hazard; hold IF/ID register and pc.
REQ-006 flush  input  1  taken branch/jump; discard fetched and in-flight instructions, redirect to next_pc.
REQ-007 imem_req  output  1  instruction-memory request valid.
REQ-008 imem_addr  output  32  instruction-memory word address.
REQ-009 imem_ready  input  1  memory completes current request; imem_rdata valid this cycle.
REQ-010 imem_rdata  input  32  instruction word.
REQ-011 pc  output  32  current fetch address; drives the branch-target stage address input.
REQ-012 if_id_inst  output  32  registered instruction to decode.
REQ-013 if_id_pc  output  32  registered address of if_id_inst.
REQ-014 if_id_valid  output  1  if_id_inst is a live instruction.

Function
REQ-015 FSM states: FETCH (request pc), HOLD (word captured, waiting out stall), DROP (awaiting stale response after flush).
REQ-016 Memory protocol: transfer completes on cycle with imem_req=1 and imem_ready=1; once raised, imem_req stays high with imem_addr stable until completion.
REQ-017 imem_req=1 in FETCH and DROP, 0 in HOLD and while rst_n=0; imem_addr = pc in FETCH, req_addr in DROP.
REQ-018 Priority per cycle: flush > stall > normal advance.
REQ-019 FETCH, imem_ready=1, stall=0, flush=0: if_id_inst<=imem_rdata, if_id_pc<=pc, if_id_valid<=1, pc<=next_pc; stay FETCH (one word per cycle at zero wait states).
REQ-020 FETCH, imem_ready=1, stall=1, flush=0: hold_inst<=imem_rdata; pc and IF/ID unchanged; go HOLD.
REQ-021 FETCH, imem_ready=0, flush=0: pc unchanged; if stall=0 if_id_valid<=0 (bubble), else IF/ID unchanged.
REQ-022 FETCH, flush=1, imem_ready=1: data discarded, pc<=next_pc, if_id_valid<=0, stay FETCH.
REQ-023 FETCH, flush=1, imem_ready=0: req_addr<=pc, pc<=next_pc, if_id_valid<=0, go DROP.
REQ-024 HOLD, flush=1: hold_inst discarded, pc<=next_pc, if_id_valid<=0, go FETCH.
REQ-025 HOLD, stall=0, flush=0: if_id_inst<=hold_inst, if_id_pc<=pc, if_id_valid<=1, pc<=next_pc, go FETCH.
REQ-026 HOLD, stall=1, flush=0: no change.
REQ-027 DROP: if_id_valid held 0; imem_ready=1 -> data discarded, go FETCH; flush=1 (any imem_ready) -> pc<=next_pc (latest target wins), req_addr unchanged.
REQ-028 stall never blocks flush; IF/ID fields other than if_id_valid unchanged on flush.
REQ-029 All address arithmetic is performed upstream; pc is 32-bit, no wrap checks, 32'hFFFFFFFF -> next_pc loaded as given.

Reset
REQ-030 rst_n=0 at rising edge: pc<=RESET_PC, state<=FETCH, req_addr<=0, hold_inst<=0, if_id_inst<=0, if_id_pc<=0, if_id_valid<=0; overrides flush/stall.
REQ-031 First cycle after rst_n=1: imem_req=1, imem_addr=RESET_PC.
REQ-032 Reset asserted mid-transfer (FETCH or DROP) abandons the request; memory model is reset with the block.

Verification
REQ-033 Reset, imem_ready tied 1, next_pc=pc+1, no stall/flush -> pc 0,1,2,3; if_id_pc 0,1,2 on consecutive cycles, if_id_valid=1 from cycle 2.
REQ-034 Word at addr 5 returned while stall=1 for 3 cycles -> imem_req=0 those cycles, IF/ID unchanged; stall drops -> if_id_inst=word5, if_id_pc=5, pc=next_pc.
REQ-035 imem_ready delayed 2 cycles on addr 8, flush with next_pc=32'h40 in first wait cycle -> imem_addr stays 8 until ready, returned word never reaches IF/ID, next request addr 32'h40.
REQ-036 flush and stall together in HOLD, next_pc=32'h20 -> if_id_valid=0, state FETCH, imem_addr=32'h20 next cycle.
REQ-037 flush coincident with imem_ready in FETCH, next_pc=32'h100 -> data discarded, imem_addr=32'h100 next cycle, no DROP.
REQ-038 rst_n=0 during DROP with flush=1 -> all outputs at reset values next cycle, imem_addr=RESET_PC after release.
